// File: rtl/rcc_ker_clk_pkg.sv
// ---------------------------------------------------------------------------
// rcc_ker_clk_pkg
//
// Purpose:
//     Shared types and default constants for the kernel clock-enable
//     generator. This package holds:
//       - the per-channel FSM state enum,
//       - the default values of the top-level parameters,
//       - the width of the gate-off wait counter,
//       - the helper that combines the two cores' low-power state with the
//         per-channel enable bits.
//
// Ports:
//     none (package)
// ---------------------------------------------------------------------------
package rcc_ker_clk_pkg;

    // Default values of the top-level parameters.
    localparam int CH_NUM_DEFAULT   = 4;
    localparam int DIV_W_DEFAULT    = 5;
    localparam int SEL_W_DEFAULT    = 2;
    localparam int GATE_DLY_DEFAULT = 3;

    // The gate-off delay can be at most 15 cycles, so a 4-bit down-counter
    // is wide enough to hold GATE_DLY-1.
    localparam int WAIT_W = 4;

    // Per-channel controller states.
    //   ST_OFF       : clock gated, waiting for the channel to become active
    //   ST_RUN       : dividing, one enable pulse per divide period
    //   ST_GATE_WAIT : clock held off before the source mux is touched
    //   ST_SWITCH    : the single cycle in which the new source is applied
    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RUN       = 2'd1,
        ST_GATE_WAIT = 2'd2,
        ST_SWITCH    = 2'd3
    } ch_state_e;

    // A channel wants its clock when at least one core owns it and that core
    // is awake. A core in sleep keeps the clock only if the low-power enable
    // bit is set. A core in deep-sleep never keeps it.
    function automatic logic calc_active(
        input logic c1_en,
        input logic c1_lpen,
        input logic c1_sleep,
        input logic c1_deepsleep,
        input logic c2_en,
        input logic c2_lpen,
        input logic c2_sleep,
        input logic c2_deepsleep
    );
        logic w_c1_req;
        logic w_c2_req;
        w_c1_req = c1_en & (~c1_sleep | c1_lpen) & ~c1_deepsleep;
        w_c2_req = c2_en & (~c2_sleep | c2_lpen) & ~c2_deepsleep;
        return w_c1_req | w_c2_req;
    endfunction

endpackage

// File: rtl/rcc_ker_ch_ctrl.sv
// ---------------------------------------------------------------------------
// rcc_ker_ch_ctrl
//
// Purpose:
//     Controller for one kernel clock channel. It has three jobs:
//       - divide the clock into one enable pulse per R cycles,
//       - gate that enable off around a source-mux switch,
//       - track which source is currently applied to the mux.
//
// Ports:
//     clk            in   block clock
//     rst_n          in   asynchronous active-low reset
//     i_active       in   channel requested by at least one awake core
//     i_div_ratio    in   divide ratio (0 and 1 both mean "every cycle")
//     i_src_sel      in   requested source selection
//     o_ker_en       out  registered clock-enable for the downstream ICG
//     o_src_sel_cur  out  source currently applied to the mux
//     o_sw_busy      out  a gate-off / switch sequence is in progress
// ---------------------------------------------------------------------------
module rcc_ker_ch_ctrl
    import rcc_ker_clk_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEFAULT,
    parameter int SEL_W    = SEL_W_DEFAULT,
    parameter int GATE_DLY = GATE_DLY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_active,
    input  logic [DIV_W-1:0] i_div_ratio,
    input  logic [SEL_W-1:0] i_src_sel,
    output logic             o_ker_en,
    output logic [SEL_W-1:0] o_src_sel_cur,
    output logic             o_sw_busy
);

    // Loading GATE_DLY-1 and counting down through 0 keeps the clock gated
    // for exactly GATE_DLY cycles before the switch cycle.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(GATE_DLY - 1);

    ch_state_e          r_state;
    ch_state_e          w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [DIV_W-1:0]   w_div_cnt_nxt;
    logic [DIV_W-1:0]   r_ratio;
    logic [DIV_W-1:0]   w_ratio_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_nxt;
    logic [SEL_W-1:0]   r_src_cur;
    logic [SEL_W-1:0]   w_src_cur_nxt;
    logic               r_ker_en;
    logic               w_ker_en_nxt;
    logic               r_sw_busy;
    logic               w_sw_busy_nxt;
    logic               w_period_end;

    // The divider sits on the last count of its period when the counter
    // reaches R-1. A latched ratio of 0 or 1 makes every cycle a period end.
    assign w_period_end = (r_ratio <= DIV_W'(1)) ||
                          (r_div_cnt >= (r_ratio - DIV_W'(1)));

    // Next-state logic for the channel FSM and its datapath.
    //
    // Every register keeps its value unless a transition says otherwise.
    //
    // Ratio re-latch: the ratio is only picked up when a new period begins.
    // A new period begins on OFF->RUN, on a divider wrap, and on the way out
    // of SWITCH. This lets a mid-period change of div_ratio wait until the
    // running period has finished.
    //
    // src_sel_cur timing: the new source is captured on the edge that enters
    // SWITCH. The mux therefore changes during the SWITCH cycle, while the
    // enable is still low. The enable only rises again on the cycle after.
    //
    // The enable and busy flags are computed from the next state, so that
    // both outputs come straight from flops.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_cnt_nxt  = r_div_cnt;
        w_ratio_nxt    = r_ratio;
        w_wait_cnt_nxt = r_wait_cnt;
        w_src_cur_nxt  = r_src_cur;

        case (r_state)
            ST_OFF: begin
                if (i_active) begin
                    w_state_nxt   = ST_RUN;
                    w_div_cnt_nxt = '0;
                    w_ratio_nxt   = i_div_ratio;
                end
            end

            ST_RUN: begin
                if (!i_active) begin
                    w_state_nxt   = ST_OFF;
                    w_div_cnt_nxt = '0;
                end else if (i_src_sel != r_src_cur) begin
                    w_state_nxt    = ST_GATE_WAIT;
                    w_wait_cnt_nxt = WAIT_LOAD;
                end else if (w_period_end) begin
                    w_div_cnt_nxt = '0;
                    w_ratio_nxt   = i_div_ratio;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
                end
            end

            // The wait is never restarted by a further change of src_sel,
            // and it is never aborted by loss of activity. Whatever src_sel
            // holds when the countdown expires is the value that gets applied.
            ST_GATE_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt   = ST_SWITCH;
                    w_src_cur_nxt = i_src_sel;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
                end
            end

            ST_SWITCH: begin
                w_state_nxt   = i_active ? ST_RUN : ST_OFF;
                w_div_cnt_nxt = '0;
                w_ratio_nxt   = i_div_ratio;
            end

            default: begin
                w_state_nxt   = ST_OFF;
                w_div_cnt_nxt = '0;
            end
        endcase

        w_ker_en_nxt  = (w_state_nxt == ST_RUN) && (w_div_cnt_nxt == '0);
        w_sw_busy_nxt = (w_state_nxt == ST_GATE_WAIT) ||
                        (w_state_nxt == ST_SWITCH);
    end

    // State and datapath registers.
    // Reset returns the channel to OFF and drops any pending source switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OFF;
            r_div_cnt  <= '0;
            r_ratio    <= '0;
            r_wait_cnt <= '0;
            r_src_cur  <= '0;
            r_ker_en   <= 1'b0;
            r_sw_busy  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_ratio    <= w_ratio_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_src_cur  <= w_src_cur_nxt;
            r_ker_en   <= w_ker_en_nxt;
            r_sw_busy  <= w_sw_busy_nxt;
        end
    end

    assign o_ker_en      = r_ker_en;
    assign o_src_sel_cur = r_src_cur;
    assign o_sw_busy     = r_sw_busy;

endmodule

// File: rtl/rcc_ker_clk_en_gen.sv
// ---------------------------------------------------------------------------
// rcc_ker_clk_en_gen
//
// Purpose:
//     Generates the clock-enables for CH_NUM kernel clocks. Each channel has
//     its own controller, and each controller handles:
//       - the channel's divide ratio,
//       - glitch-free source switching,
//       - gating according to the two cores' sleep and deep-sleep state.
//     Test mode forces every enable on, without disturbing the controllers.
//
// Ports:
//     clk            in   block clock
//     rst_n          in   asynchronous active-low reset
//     c1_sleep       in   core 1 in sleep
//     c1_deepsleep   in   core 1 in deep-sleep
//     c2_sleep       in   core 2 in sleep
//     c2_deepsleep   in   core 2 in deep-sleep
//     testmode       in   force all ker_clk_en bits high
//     rcc_c1_en      in   [CH_NUM]        core 1 run-mode enable per channel
//     rcc_c2_en      in   [CH_NUM]        core 2 run-mode enable per channel
//     rcc_c1_lpen    in   [CH_NUM]        core 1 sleep-mode enable per channel
//     rcc_c2_lpen    in   [CH_NUM]        core 2 sleep-mode enable per channel
//     div_ratio      in   [CH_NUM*DIV_W]  divide ratio per channel
//     src_sel        in   [CH_NUM*SEL_W]  requested source per channel
//     ker_clk_en     out  [CH_NUM]        clock-enable to downstream ICG
//     src_sel_cur    out  [CH_NUM*SEL_W]  source applied to each mux
//     sw_busy        out  [CH_NUM]        switch sequence in progress
// ---------------------------------------------------------------------------
module rcc_ker_clk_en_gen
    import rcc_ker_clk_pkg::*;
#(
    parameter int CH_NUM   = CH_NUM_DEFAULT,
    parameter int DIV_W    = DIV_W_DEFAULT,
    parameter int SEL_W    = SEL_W_DEFAULT,
    parameter int GATE_DLY = GATE_DLY_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    c1_sleep,
    input  logic                    c1_deepsleep,
    input  logic                    c2_sleep,
    input  logic                    c2_deepsleep,
    input  logic                    testmode,
    input  logic [CH_NUM-1:0]       rcc_c1_en,
    input  logic [CH_NUM-1:0]       rcc_c2_en,
    input  logic [CH_NUM-1:0]       rcc_c1_lpen,
    input  logic [CH_NUM-1:0]       rcc_c2_lpen,
    input  logic [CH_NUM*DIV_W-1:0] div_ratio,
    input  logic [CH_NUM*SEL_W-1:0] src_sel,
    output logic [CH_NUM-1:0]       ker_clk_en,
    output logic [CH_NUM*SEL_W-1:0] src_sel_cur,
    output logic [CH_NUM-1:0]       sw_busy
);

    logic [CH_NUM-1:0] w_active;
    logic [CH_NUM-1:0] w_ker_en_reg;

    // One controller per channel. Each channel sees the shared core
    // low-power state together with its own enable bits.
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        assign w_active[g] = calc_active(rcc_c1_en[g], rcc_c1_lpen[g],
                                         c1_sleep, c1_deepsleep,
                                         rcc_c2_en[g], rcc_c2_lpen[g],
                                         c2_sleep, c2_deepsleep);

        rcc_ker_ch_ctrl #(
            .DIV_W    (DIV_W),
            .SEL_W    (SEL_W),
            .GATE_DLY (GATE_DLY)
        ) u_ch_ctrl (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_active      (w_active[g]),
            .i_div_ratio   (div_ratio[g*DIV_W +: DIV_W]),
            .i_src_sel     (src_sel[g*SEL_W +: SEL_W]),
            .o_ker_en      (w_ker_en_reg[g]),
            .o_src_sel_cur (src_sel_cur[g*SEL_W +: SEL_W]),
            .o_sw_busy     (sw_busy[g])
        );
    end

    // Test mode overrides the enables directly, so that scan and test clocks
    // reach every kernel even while reset is held. The controllers keep
    // running underneath, and the normal enables return as soon as
    // testmode drops.
    assign ker_clk_en = w_ker_en_reg | {CH_NUM{testmode}};

endmodule

// File: tb/tb_rcc_ker_clk_en_gen.sv
// ---------------------------------------------------------------------------
// tb_rcc_ker_clk_en_gen
//
// Purpose:
//     Self-checking bench for rcc_ker_clk_en_gen.
//
//     The reference model describes each channel in terms of:
//       - whether it is on,
//       - how many switch-busy cycles remain,
//       - its phase within the current divide period,
//       - the source it currently uses.
//     The model is stepped once per rising edge. Directed scenarios also
//     compare against hand-written constant patterns.
// ---------------------------------------------------------------------------
module tb_rcc_ker_clk_en_gen;

    localparam int CH = 4;
    localparam int DW = 5;
    localparam int SW = 2;
    localparam int GD = 3;

    logic            clk = 1'b0;
    logic            rstN;
    logic            c1Sleep, c1Deepsleep, c2Sleep, c2Deepsleep, testMode;
    logic [CH-1:0]   c1En, c2En, c1Lpen, c2Lpen;
    logic [CH*DW-1:0] divRatio;
    logic [CH*SW-1:0] srcSel;
    logic [CH-1:0]   kerClkEn;
    logic [CH*SW-1:0] srcSelCur;
    logic [CH-1:0]   swBusy;

    int nChecks = 0;
    int nFail   = 0;

    int mOn[CH];
    int mPhase[CH];
    int mPeriod[CH];
    int mBusyLeft[CH];
    int mCurSel[CH];

    rcc_ker_clk_en_gen #(
        .CH_NUM   (CH),
        .DIV_W    (DW),
        .SEL_W    (SW),
        .GATE_DLY (GD)
    ) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .c1_sleep     (c1Sleep),
        .c1_deepsleep (c1Deepsleep),
        .c2_sleep     (c2Sleep),
        .c2_deepsleep (c2Deepsleep),
        .testmode     (testMode),
        .rcc_c1_en    (c1En),
        .rcc_c2_en    (c2En),
        .rcc_c1_lpen  (c1Lpen),
        .rcc_c2_lpen  (c2Lpen),
        .div_ratio    (divRatio),
        .src_sel      (srcSel),
        .ker_clk_en   (kerClkEn),
        .src_sel_cur  (srcSelCur),
        .sw_busy      (swBusy)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Divide period for a channel's current div_ratio input.
    // Ratios 0 and 1 both mean "every cycle".
    function automatic int effRatio(input int ch);
        int r;
        r = int'(divRatio[ch*DW +: DW]);
        return (r < 2) ? 1 : r;
    endfunction

    // A channel is wanted if an awake core owns it.
    // A sleeping core needs lpen to keep it; a deep-sleeping core never does.
    function automatic bit chActive(input int ch);
        bit c1Ok;
        bit c2Ok;
        c1Ok = c1En[ch] && (!c1Sleep || c1Lpen[ch]) && !c1Deepsleep;
        c2Ok = c2En[ch] && (!c2Sleep || c2Lpen[ch]) && !c2Deepsleep;
        return c1Ok || c2Ok;
    endfunction

    // Return every channel of the model to its reset condition.
    task automatic modelReset();
        for (int ch = 0; ch < CH; ch++) begin
            mOn[ch] = 0;
            mPhase[ch] = 0;
            mPeriod[ch] = 1;
            mBusyLeft[ch] = 0;
            mCurSel[ch] = 0;
        end
    endtask

    // Advance the model by one rising edge, using the inputs as they stand
    // at that edge.
    // A switch keeps the channel busy for GD+1 cycles. The new source is
    // taken on the edge that starts the last busy cycle. When the sequence
    // ends, the channel is on again only if it is still wanted.
    task automatic modelStep();
        for (int ch = 0; ch < CH; ch++) begin
            bit a;
            int sel;
            a = chActive(ch);
            sel = int'(srcSel[ch*SW +: SW]);
            if (mBusyLeft[ch] > 0) begin
                mBusyLeft[ch]--;
                if (mBusyLeft[ch] == 1) begin
                    mCurSel[ch] = sel;
                end else if (mBusyLeft[ch] == 0) begin
                    mOn[ch] = a ? 1 : 0;
                    mPhase[ch] = 0;
                    mPeriod[ch] = effRatio(ch);
                end
            end else if (mOn[ch] == 0) begin
                if (a) begin
                    mOn[ch] = 1;
                    mPhase[ch] = 0;
                    mPeriod[ch] = effRatio(ch);
                end
            end else if (!a) begin
                mOn[ch] = 0;
            end else if (sel != mCurSel[ch]) begin
                mBusyLeft[ch] = GD + 1;
            end else begin
                mPhase[ch]++;
                if (mPhase[ch] >= mPeriod[ch]) begin
                    mPhase[ch] = 0;
                    mPeriod[ch] = effRatio(ch);
                end
            end
        end
    endtask

    // Expected {ker_clk_en, sw_busy, src_sel_cur} from the model state.
    function automatic logic [CH*(2+SW)-1:0] expAll();
        logic [CH-1:0]    k;
        logic [CH-1:0]    b;
        logic [CH*SW-1:0] c;
        k = '0;
        b = '0;
        c = '0;
        for (int ch = 0; ch < CH; ch++) begin
            k[ch] = ((mOn[ch] != 0) && (mBusyLeft[ch] == 0) && (mPhase[ch] == 0)) || testMode;
            b[ch] = (mBusyLeft[ch] > 0);
            c[ch*SW +: SW] = SW'(mCurSel[ch]);
        end
        return {k, b, c};
    endfunction

    // One clock: the model follows the rising edge, and control returns
    // on the falling edge so that outputs can be sampled away from the
    // active edge.
    task automatic tick();
        @(posedge clk);
        if (rstN) modelStep();
        @(negedge clk);
    endtask

    // Quiet all request inputs.
    // Each requested source is set to the one the model says is applied,
    // so that a later enable does not trigger a switch.
    task automatic applyIdle();
        c1En = '0;
        c2En = '0;
        c1Lpen = '0;
        c2Lpen = '0;
        c1Sleep = 1'b0;
        c1Deepsleep = 1'b0;
        c2Sleep = 1'b0;
        c2Deepsleep = 1'b0;
        testMode = 1'b0;
        for (int ch = 0; ch < CH; ch++) srcSel[ch*SW +: SW] = SW'(mCurSel[ch]);
    endtask

    // Idle long enough for any in-flight switch to finish.
    task automatic settle();
        applyIdle();
        repeat (GD + 4) tick();
        applyIdle();
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        divRatio = '0;
        modelReset();
        applyIdle();
        c1En = '1;
        #2 rstN = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({kerClkEn, swBusy, srcSelCur} !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_outputs: got %h want 0", {kerClkEn, swBusy, srcSelCur});
        end
        testMode = 1'b1;
        #1;
        nChecks++;
        if (kerClkEn !== 4'hF) begin
            nFail++;
            $display("[TB] FAIL reset_testmode: got %h want f", kerClkEn);
        end
        applyIdle();
        @(negedge clk);
        rstN = 1'b1;
        modelReset();
    endtask

    task automatic test_divider();
        settle();
        divRatio[0 +: DW] = DW'(4);
        c1En[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            nChecks++;
            if (kerClkEn[0] !== ((i % 4) == 0)) begin
                nFail++;
                $display("[TB] FAIL divider_pattern cyc %0d: got %b want %b", i, kerClkEn[0], (i % 4) == 0);
            end
            nChecks++;
            if ({kerClkEn, swBusy, srcSelCur} !== expAll()) begin
                nFail++;
                $display("[TB] FAIL divider_model cyc %0d: got %h want %h", i, {kerClkEn, swBusy, srcSelCur}, expAll());
            end
        end
    endtask

    // Three switch sequences on channel 1:
    //   a plain switch 0->2,
    //   a switch whose request changes during the wait (the last value wins),
    //   a switch during which the channel loses activity
    //   (the sequence completes, then the channel stays off).
    task automatic test_switch();
        int newSel[3];
        int midSel[3];
        int oldSel[3];
        int endKer[3];
        newSel = '{2, 1, 0};
        midSel = '{2, 3, 0};
        oldSel = '{0, 2, 3};
        endKer = '{1, 1, 0};
        settle();
        divRatio[1*DW +: DW] = DW'(2);
        c1En[1] = 1'b1;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            srcSel[1*SW +: SW] = SW'(newSel[s]);
            for (int i = 0; i < 6; i++) begin
                logic [3:0] expC;
                logic [3:0] got;
                tick();
                expC = {(i == 4) ? endKer[s][0] : 1'b0, (i < 4), SW'((i >= 3) ? midSel[s] : oldSel[s])};
                got = {kerClkEn[1], swBusy[1], srcSelCur[1*SW +: SW]};
                if (i < 5) begin
                    nChecks++;
                    if (got !== expC) begin
                        nFail++;
                        $display("[TB] FAIL switch_seq%0d cyc %0d: got %h want %h", s, i, got, expC);
                    end
                end
                nChecks++;
                if ({kerClkEn, swBusy, srcSelCur} !== expAll()) begin
                    nFail++;
                    $display("[TB] FAIL switch_model%0d cyc %0d: got %h want %h", s, i, {kerClkEn, swBusy, srcSelCur}, expAll());
                end
                if (i == 0 && s == 1) srcSel[1*SW +: SW] = SW'(3);
                if (i == 0 && s == 2) c1En[1] = 1'b0;
            end
        end
    endtask

    // Four low-power stages on channel 2, running at ratio 1 so that the
    // enable is high every cycle while the channel is on:
    //   awake, sleep with lpen=0, sleep with lpen=1, deep-sleep with lpen=1.
    task automatic test_sleep();
        bit stSleep[4];
        bit stLpen[4];
        bit stDeep[4];
        bit stKer[4];
        stSleep = '{0, 1, 1, 1};
        stLpen  = '{0, 0, 1, 1};
        stDeep  = '{0, 0, 0, 1};
        stKer   = '{1, 0, 1, 0};
        settle();
        divRatio[2*DW +: DW] = DW'(1);
        c1En[2] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            c1Sleep = stSleep[s];
            c1Lpen[2] = stLpen[s];
            c1Deepsleep = stDeep[s];
            for (int i = 0; i < 2; i++) begin
                tick();
                nChecks++;
                if (kerClkEn[2] !== stKer[s]) begin
                    nFail++;
                    $display("[TB] FAIL sleep_stage%0d cyc %0d: got %b want %b", s, i, kerClkEn[2], stKer[s]);
                end
                nChecks++;
                if ({kerClkEn, swBusy, srcSelCur} !== expAll()) begin
                    nFail++;
                    $display("[TB] FAIL sleep_model%0d cyc %0d: got %h want %h", s, i, {kerClkEn, swBusy, srcSelCur}, expAll());
                end
            end
        end
    endtask

    // The ratio changes from 5 to 2 while the counter sits at 2.
    // The period of 5 finishes first, then pulses come every 2 cycles.
    task automatic test_ratio_change();
        settle();
        divRatio[0 +: DW] = DW'(5);
        c1En[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bit expK;
            tick();
            expK = (i == 0) || (i == 5) || (i == 7) || (i == 9) || (i == 11);
            nChecks++;
            if (kerClkEn[0] !== expK) begin
                nFail++;
                $display("[TB] FAIL ratio_change cyc %0d: got %b want %b", i, kerClkEn[0], expK);
            end
            nChecks++;
            if ({kerClkEn, swBusy, srcSelCur} !== expAll()) begin
                nFail++;
                $display("[TB] FAIL ratio_model cyc %0d: got %h want %h", i, {kerClkEn, swBusy, srcSelCur}, expAll());
            end
            if (i == 2) divRatio[0 +: DW] = DW'(2);
        end
    endtask

    // Reset asserted while channel 1 is in the gate-off wait.
    // The pending source is discarded, and after release the channel starts
    // again from OFF.
    task automatic test_reset_mid_switch();
        int target;
        settle();
        divRatio[1*DW +: DW] = DW'(3);
        c1En[1] = 1'b1;
        repeat (2) tick();
        target = (mCurSel[1] == 2) ? 1 : 2;
        srcSel[1*SW +: SW] = SW'(target);
        repeat (2) tick();
        #2 rstN = 1'b0;
        #1;
        nChecks++;
        if ({kerClkEn, swBusy, srcSelCur} !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_mid_switch: got %h want 0", {kerClkEn, swBusy, srcSelCur});
        end
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] got;
            tick();
            got = {kerClkEn[1], swBusy[1], srcSelCur[1*SW +: SW]};
            if (i < 2) begin
                nChecks++;
                if (got !== {(i == 0), (i == 1), 2'b00}) begin
                    nFail++;
                    $display("[TB] FAIL after_reset cyc %0d: got %h want %h", i, got, {(i == 0), (i == 1), 2'b00});
                end
            end
            nChecks++;
            if ({kerClkEn, swBusy, srcSelCur} !== expAll()) begin
                nFail++;
                $display("[TB] FAIL after_reset_model cyc %0d: got %h want %h", i, {kerClkEn, swBusy, srcSelCur}, expAll());
            end
        end
    endtask

    // With every channel disabled, test mode alone drives the enables high
    // straight away, and they drop again at the next cycle once it clears.
    task automatic test_testmode();
        settle();
        testMode = 1'b1;
        #1;
        nChecks++;
        if (kerClkEn !== 4'hF) begin
            nFail++;
            $display("[TB] FAIL testmode_on: got %h want f", kerClkEn);
        end
        repeat (2) tick();
        nChecks++;
        if (kerClkEn !== 4'hF) begin
            nFail++;
            $display("[TB] FAIL testmode_hold: got %h want f", kerClkEn);
        end
        testMode = 1'b0;
        tick();
        nChecks++;
        if (kerClkEn !== 4'h0) begin
            nFail++;
            $display("[TB] FAIL testmode_off: got %h want 0", kerClkEn);
        end
    endtask

    // Randomized traffic on all channels.
    // Inputs change occasionally rather than every cycle, so that runs,
    // switches and sleep periods last long enough to matter.
    task automatic test_random();
        settle();
        c1En = CH'($urandom);
        c2En = CH'($urandom);
        for (int i = 0; i < 600; i++) begin
            tick();
            nChecks++;
            if ({kerClkEn, swBusy, srcSelCur} !== expAll()) begin
                nFail++;
                $display("[TB] FAIL random_model cyc %0d: got %h want %h", i, {kerClkEn, swBusy, srcSelCur}, expAll());
            end
            if ($urandom_range(0, 7) == 0) c1En = CH'($urandom);
            if ($urandom_range(0, 7) == 0) c2En = CH'($urandom);
            if ($urandom_range(0, 9) == 0) c1Lpen = CH'($urandom);
            if ($urandom_range(0, 9) == 0) c2Lpen = CH'($urandom);
            if ($urandom_range(0, 11) == 0) c1Sleep = 1'($urandom);
            if ($urandom_range(0, 11) == 0) c2Sleep = 1'($urandom);
            if ($urandom_range(0, 19) == 0) c1Deepsleep = 1'($urandom);
            if ($urandom_range(0, 19) == 0) c2Deepsleep = 1'($urandom);
            if ($urandom_range(0, 29) == 0) testMode = 1'($urandom);
            for (int ch = 0; ch < CH; ch++) begin
                if ($urandom_range(0, 11) == 0) srcSel[ch*SW +: SW] = SW'($urandom);
                if ($urandom_range(0, 9) == 0) divRatio[ch*DW +: DW] = DW'($urandom_range(0, 7));
            end
        end
    endtask

    // Run the scenarios in order, then print the summary line.
    initial begin
        test_reset();
        test_divider();
        test_switch();
        test_sleep();
        test_ratio_change();
        test_reset_mid_switch();
        test_testmode();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/rcc_ker_clk_en_gen.md
RCC_KER_CLK_EN_GEN -- requirements
Module: rcc_ker_clk_en_gen

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of kernel clock channels.
REQ-002 SHALL have parameter DIV_W, default 5, divide-ratio field width per channel.
REQ-003 SHALL have parameter SEL_W, default 2, source-select field width per channel.
REQ-004 SHALL have parameter GATE_DLY, default 3, gate-off cycles before a source switch (range 1..15).
REQ-005 SHALL have port clk  in  1  single clock for the block.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports c1_sleep, c1_deepsleep, c2_sleep, c2_deepsleep  in  1 each  core low-power states.
REQ-008 SHALL have port testmode  in  1  forces all enables on.
REQ-009 SHALL have ports rcc_c1_en, rcc_c2_en, rcc_c1_lpen, rcc_c2_lpen  in  CH_NUM each  per-channel register bits.
REQ-010 SHALL have port div_ratio  in  CH_NUM*DIV_W  per-channel divide ratio.
REQ-011 SHALL have port src_sel  in  CH_NUM*SEL_W  requested source per channel.
REQ-012 SHALL have port ker_clk_en  out  CH_NUM  per-channel clock-enable to downstream ICG.
REQ-013 SHALL have port src_sel_cur  out  CH_NUM*SEL_W  source currently applied to the mux.
REQ-014 SHALL have port sw_busy  out  CH_NUM  switch sequence in progress.

Function
REQ-015 SHALL compute per channel active = (c1_en & (~c1_sleep | c1_lpen) & ~c1_deepsleep) | (c2_en & (~c2_sleep | c2_lpen) & ~c2_deepsleep).
REQ-016 SHALL run one independent FSM per channel: OFF, RUN, GATE_WAIT, SWITCH.
REQ-017 OFF: active sampled 1 -> RUN next cycle, div counter cleared to 0, ratio latched.
REQ-018 RUN: !active -> OFF; else src_sel != src_sel_cur -> GATE_WAIT with wait counter loaded GATE_DLY-1; !active has priority.
REQ-019 GATE_WAIT: count down each cycle; at 0 -> SWITCH.
REQ-020 SWITCH: one cycle; src_sel_cur loaded from src_sel sampled this cycle; -> RUN if active else OFF; div counter cleared.
REQ-021 src_sel changes during GATE_WAIT SHALL NOT restart the wait; latest value wins at SWITCH.
REQ-022 !active during GATE_WAIT/SWITCH SHALL NOT abort the sequence; OFF entered after SWITCH.
REQ-023 Divider in RUN: counter 0..R-1, wraps to 0; R = latched ratio; R of 0 or 1 treated as 1.
REQ-024 Ratio SHALL be re-latched only when counter wraps to 0; mid-period div_ratio changes ignored until then.
REQ-025 ker_clk_en SHALL be 1 exactly when state==RUN and counter==0; all outputs driven from registers only.
REQ-026 ker_clk_en SHALL be 0 in OFF, GATE_WAIT, SWITCH (never high on the cycle src_sel_cur changes).
REQ-027 sw_busy SHALL be 1 in GATE_WAIT and SWITCH, else 0.
REQ-028 testmode=1 SHALL force ker_clk_en all-ones combinationally; FSMs continue unchanged.
REQ-029 Latency: active rising at cycle t -> ker_clk_en=1 at t+1.

Reset
REQ-030 rst_n low SHALL asynchronously set state OFF, counters 0, src_sel_cur 0, ker_clk_en 0 (unless testmode), sw_busy 0.
REQ-031 Reset release SHALL resume from OFF; reset mid-switch discards the pending selection.

Structure
REQ-032 Package rcc_ker_clk_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Per-channel logic SHALL be sub-module rcc_ker_ch_ctrl, instantiated CH_NUM times in a generate loop.

Verification
REQ-034 c1_en[0]=1, ratio 4, no sleep -> ker_clk_en[0] pulses every 4th cycle, first pulse 1 cycle after enable.
REQ-035 RUN ch1, src_sel 0->2, GATE_DLY=3 -> ker_clk_en[1]=0 for 4 cycles, src_sel_cur=2 on SWITCH, sw_busy high 4 cycles, pulses resume.
REQ-036 c1_sleep=1 with lpen=0 then lpen=1 -> channel goes OFF, then stays RUN; c1_deepsleep=1 -> OFF regardless of lpen.
REQ-037 ratio 5->2 written at counter 2 -> old period of 5 completes, then period 2.
REQ-038 rst_n low during GATE_WAIT -> all outputs 0 immediately; after release src_sel_cur=0 and FSM re-evaluates from OFF.
REQ-039 testmode=1 with all en=0 -> ker_clk_en all-ones; testmode=0 -> all 0 next cycle.
